branch_resolution_queue: RTL
============================

Name: branch_resolution_queue

Overview:
- In-order FIFO of in-flight branch predictions, sitting between fetch-stage prediction and the branch history table write port.
- Fetch pushes each predicted branch's index, tag and predicted 2-bit count.
- When execute resolves the oldest branch, the block pops it and drives a one-cycle BHT update: write enable, index, tag, and increment/decrement.
- It also flags mispredicts and discards younger wrong-path entries.

Parameters:
- INDEX_LEN, 7, BHT index width.
- TAG_LEN, 7, BHT tag width.
- DEPTH, 4, queue entries; power of two, >= 2.
- PTR_LEN, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- push_valid  input  1  fetch presents a predicted branch.
- push_index  input  INDEX_LEN  BHT index of the branch.
- push_tag  input  TAG_LEN  BHT tag of the branch.
- push_count  input  2  counter value read at prediction; bit 1 = predicted taken.
- push_ready  output  1  queue can accept; equals !full.
- resolve_valid  input  1  execute resolves the oldest queued branch.
- resolve_taken  input  1  actual outcome.
- flush  input  1  external pipeline flush; empties queue.
- bht_write_enabled  output  1  one-cycle update pulse.
- bht_index_write  output  INDEX_LEN  update index.
- bht_tag_write  output  TAG_LEN  update tag.
- bht_increment_decrement  output  1  1 = increment (taken), 0 = decrement.
- mispredict  output  1  one-cycle pulse, aligned with bht_write_enabled.
- occupancy  output  PTR_LEN+1  entries held, 0..DEPTH.
- empty  output  1  occupancy == 0.
- full  output  1  occupancy == DEPTH.
- underflow_err  output  1  sticky; set when resolve_valid arrives while empty.

Behaviour:
- Reset (async) values:
  - Head/tail pointers and occupancy are 0; empty = 1; full = 0; push_ready = 1.
  - bht_write_enabled, bht_increment_decrement, mispredict and underflow_err are 0.
  - bht_index_write and bht_tag_write are 0.
  - Entry storage is not reset; it is qualified by occupancy.
- Push: accepted on a clock edge when push_valid && !full. The entry is written at tail and tail increments modulo DEPTH. Push while full is dropped, with no state change.
- Resolve: effective when resolve_valid && !empty.
  - The head entry is popped and head increments modulo DEPTH.
  - Registered outputs, one cycle after the resolve edge:
    - bht_write_enabled = 1.
    - bht_index_write and bht_tag_write = head entry.
    - bht_increment_decrement = resolve_taken.
    - mispredict = (head count[1] != resolve_taken).
  - In all other cycles, bht_write_enabled and mispredict are 0. bht_index_write, bht_tag_write and bht_increment_decrement hold their last values.
- Resolve while empty: no pop and no write pulse; underflow_err sets and holds until reset.
- Simultaneous push and resolve, no mispredict, not flushed: both occur and occupancy is unchanged. When full, the push is still refused, because push_ready = !full is evaluated before the pop.
- Mispredict on resolve: the resolved entry produces its update normally. All younger entries are discarded in the same edge (occupancy becomes 0, head = tail). A push in that same cycle is dropped as wrong-path.
- Flush: empties the queue on that edge (occupancy becomes 0) and drops any same-cycle push. A same-cycle effective resolve still pops and produces its BHT update and mispredict pulse.
- Pointers wrap from DEPTH-1 to 0. occupancy is its own counter, so full and empty are never ambiguous.
- Occupancy arithmetic: +1 on accepted push, -1 on effective pop. Flush or mispredict overrides to 0.
- Reset mid-operation: all in-flight entries are lost, and any pending output pulse is suppressed the following cycle.

Test Plan:
- Reset, push 4 entries (index 0x05/tag 0x11/count 2'b10, then 0x06/0x12/01, 0x07/0x13/11, 0x08/0x14/00) -> full = 1, push_ready = 0, occupancy = 4; a 5th push is ignored and occupancy stays 4.
- Resolve the first entry with taken = 1 -> the next cycle shows bht_write_enabled = 1, index 0x05, tag 0x11, increment_decrement = 1, mispredict = 0, occupancy = 3.
- Resolve the 0x06 entry (count 01) with taken = 1 while 0x07 and 0x08 are queued -> the update shows index 0x06 with mispredict = 1; occupancy = 0, empty = 1; a same-cycle push is dropped.
- Hold the queue at occupancy 2, then push and resolve in the same cycle for DEPTH+3 iterations -> occupancy stays 2, and the pointers wrap with FIFO order preserved through the sequence of update indices.
- Assert flush and resolve together at occupancy 3 -> one update pulse for the head entry, then occupancy = 0; later resolves set underflow_err = 1 and produce no write pulse.
- Assert reset asynchronously mid-stream with bht_write_enabled pending -> all outputs return to reset values immediately, and no pulse appears after reset is released.

Source files
------------

// File: rtl/branch_resolution_queue_if.sv
// Bundle of the fetch-push, execute-resolve and BHT-update signals of the branch resolution queue.
// The master side is the pipeline that pushes and resolves. The slave side is the queue itself.
interface branch_resolution_queue_if #(
   parameter int INDEX_LEN = 7,
   parameter int TAG_LEN   = 7,
   parameter int DEPTH     = 4
);
   localparam int PTR_LEN = $clog2(DEPTH);

   logic                 push_valid;
   logic [INDEX_LEN-1:0] push_index;
   logic [TAG_LEN-1:0]   push_tag;
   logic [1:0]           push_count;
   logic                 push_ready;
   logic                 resolve_valid;
   logic                 resolve_taken;
   logic                 flush;
   logic                 bht_write_enabled;
   logic [INDEX_LEN-1:0] bht_index_write;
   logic [TAG_LEN-1:0]   bht_tag_write;
   logic                 bht_increment_decrement;
   logic                 mispredict;
   logic [PTR_LEN:0]     occupancy;
   logic                 empty;
   logic                 full;
   logic                 underflow_err;

   modport master (
      output push_valid, push_index, push_tag, push_count,
      output resolve_valid, resolve_taken, flush,
      input  push_ready, bht_write_enabled, bht_index_write, bht_tag_write,
      input  bht_increment_decrement, mispredict, occupancy, empty, full, underflow_err
   );

   modport slave (
      input  push_valid, push_index, push_tag, push_count,
      input  resolve_valid, resolve_taken, flush,
      output push_ready, bht_write_enabled, bht_index_write, bht_tag_write,
      output bht_increment_decrement, mispredict, occupancy, empty, full, underflow_err
   );
endinterface

// File: rtl/branch_resolution_queue.sv
// In-order queue of in-flight branch predictions. It pops the oldest entry on resolve and
// issues a one-cycle BHT update. A mispredict or a flush discards the younger entries.
module branch_resolution_queue #(
   parameter int INDEX_LEN = 7,
   parameter int TAG_LEN   = 7,
   parameter int DEPTH     = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   branch_resolution_queue_if.slave bus
);
   localparam int PTR_LEN = $clog2(DEPTH);
   localparam logic [PTR_LEN:0] OCC_ONE  = (PTR_LEN+1)'(1);
   localparam logic [PTR_LEN:0] OCC_FULL = (PTR_LEN+1)'(DEPTH);

   typedef struct packed {
      logic [INDEX_LEN-1:0] index;
      logic [TAG_LEN-1:0]   tag;
      logic [1:0]           count;
   } entry_t;

   entry_t               mem [DEPTH];
   logic [PTR_LEN-1:0]   head, tail;
   logic [PTR_LEN:0]     occupancy, occ_next;
   logic                 empty, full;
   logic                 push_ok, pop_ok, mis, discard, push_write;
   entry_t               head_entry;
   logic                 we_q, mis_q, incdec_q, underflow_q;
   logic [INDEX_LEN-1:0] index_q;
   logic [TAG_LEN-1:0]   tag_q;

   assign empty = (occupancy == '0);
   assign full  = (occupancy == OCC_FULL);

   // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
   always_comb begin
      occ_next   = occupancy;
      head_entry = mem[head];
      push_ok    = bus.push_valid && !full;
      pop_ok     = bus.resolve_valid && !empty;
      mis        = pop_ok && (head_entry.count[1] != bus.resolve_taken);
      discard    = bus.flush || mis;
      push_write = push_ok && !discard;
      if (discard)
         occ_next = '0;
      else if (push_write && !pop_ok)
         occ_next = occupancy + OCC_ONE;
      else if (pop_ok && !push_write)
         occ_next = occupancy - OCC_ONE;
   end

   // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head      <= '0;
         tail      <= '0;
         occupancy <= '0;
      end else begin
         occupancy <= occ_next;
         if (discard) begin
            head <= tail;
         end else begin
            if (pop_ok)     head <= head + 1'b1;
            if (push_write) tail <= tail + 1'b1;
         end
      end
   end

   // NOTE: entry storage has no reset. Occupancy alone decides which slots are meaningful.
   always_ff @(posedge clk) begin
      if (push_write)
         mem[tail] <= {bus.push_index, bus.push_tag, bus.push_count};
   end

   // Update payload holds its last value between pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we_q        <= 1'b0;
         mis_q       <= 1'b0;
         incdec_q    <= 1'b0;
         index_q     <= '0;
         tag_q       <= '0;
         underflow_q <= 1'b0;
      end else begin
         we_q  <= pop_ok;
         mis_q <= mis;
         if (pop_ok) begin
            index_q  <= head_entry.index;
            tag_q    <= head_entry.tag;
            incdec_q <= bus.resolve_taken;
         end
         if (bus.resolve_valid && empty)
            underflow_q <= 1'b1;
      end
   end

   assign bus.push_ready              = !full;
   assign bus.occupancy               = occupancy;
   assign bus.empty                   = empty;
   assign bus.full                    = full;
   assign bus.bht_write_enabled       = we_q;
   assign bus.mispredict              = mis_q;
   assign bus.bht_increment_decrement = incdec_q;
   assign bus.bht_index_write         = index_q;
   assign bus.bht_tag_write           = tag_q;
   assign bus.underflow_err           = underflow_q;
endmodule
